// File: rtl/microwave_ctrl_param_pkg.sv
// Shared definitions for the microwave controller.
// Contents: FSM state encoding, keypad width, BCD and 7-segment constants,
// the power-level duty table and small keypad helper functions.
package microwave_ctrl_param_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned KEYS = 32'd10;

  localparam logic [3:0] BCD_NINE     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] SEC_TENS_LIM = 4'd6;

  // Active-high gfedcba patterns.
  localparam logic [6:0] SEG_ZERO  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Magnetron on-time in tenths of the duty window for each power_sel code.
  function automatic int unsigned pwr_tenths(input logic [1:0] sel);
    case (sel)
      2'd0:    return 32'd10;
      2'd1:    return 32'd7;
      2'd2:    return 32'd5;
      default: return 32'd3;
    endcase
  endfunction

  // True when exactly one key line is asserted.
  function automatic logic is_onehot(input logic [KEYS-1:0] v);
    return (v != {KEYS{1'b0}}) && ((v & (v - {{(KEYS-1){1'b0}}, 1'b1})) == {KEYS{1'b0}});
  endfunction

  // Index of the asserted key line; only meaningful for one-hot input.
  function automatic logic [3:0] onehot_to_bcd(input logic [KEYS-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < KEYS; k++) begin
      r = v[k] ? 4'(k) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_ctrl_param_if.sv
// Front-panel / display bundle of the microwave controller.
// master: panel side (drives keys, buttons, door, power select).
// slave : controller side (drives digits, segments, magnetron, status).
// digits_bcd = {min..., sec_tens, sec_ones}; segs uses the same digit order.
interface microwave_ctrl_param_if
  import microwave_ctrl_param_pkg::*;
#(
  parameter int MIN_DIGITS = 1
);
  localparam int D = MIN_DIGITS + 2;

  logic [KEYS-1:0] keypad;
  logic            startn;
  logic            stopn;
  logic            clearn;
  logic            door_closed;
  logic [1:0]      power_sel;
  logic [4*D-1:0]  digits_bcd;
  logic [7*D-1:0]  segs;
  logic            mag_on;
  logic            timer_done;
  logic [1:0]      state_o;

  modport master (
    output keypad, startn, stopn, clearn, door_closed, power_sel,
    input  digits_bcd, segs, mag_on, timer_done, state_o
  );

  modport slave (
    input  keypad, startn, stopn, clearn, door_closed, power_sel,
    output digits_bcd, segs, mag_on, timer_done, state_o
  );
endinterface

// File: rtl/microwave_ctrl_param_bcd_to_7seg.sv
// BCD digit to 7-segment decoder.
// i_bcd : 4-bit BCD digit
// o_seg : active-high gfedcba; codes above 9 are blanked
module microwave_ctrl_param_bcd_to_7seg
  import microwave_ctrl_param_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Segment lookup.
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_ZERO;
      4'd1:    o_seg = 7'h06;
      4'd2:    o_seg = 7'h5B;
      4'd3:    o_seg = 7'h4F;
      4'd4:    o_seg = 7'h66;
      4'd5:    o_seg = 7'h6D;
      4'd6:    o_seg = 7'h7D;
      4'd7:    o_seg = 7'h07;
      4'd8:    o_seg = 7'h7F;
      4'd9:    o_seg = 7'h6F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave_ctrl_param.sv
// Microwave cooking controller: debounced keypad entry, BCD MM:SS timer with
// normalisation on start, IDLE/COOK/PAUSE/DONE FSM and magnetron duty cycling.
// clock  : system clock, rising edge
// resetn : synchronous active-low reset
// bus    : panel/display bundle (slave side), see microwave_ctrl_param_if
module microwave_ctrl_param
  import microwave_ctrl_param_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 100,
  parameter int DEBOUNCE   = 4,
  parameter int PWR_WINDOW = 10
) (
  input logic                   clock,
  input logic                   resetn,
  microwave_ctrl_param_if.slave bus
);

  localparam int D      = MIN_DIGITS + 2;
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int DB_W   = $clog2(DEBOUNCE + 2);
  localparam int WIN_W  = $clog2(PWR_WINDOW + 1);

  localparam logic [WIN_W-1:0] ON_SECS_0 = WIN_W'(PWR_WINDOW * pwr_tenths(2'd0) / 10);
  localparam logic [WIN_W-1:0] ON_SECS_1 = WIN_W'(PWR_WINDOW * pwr_tenths(2'd1) / 10);
  localparam logic [WIN_W-1:0] ON_SECS_2 = WIN_W'(PWR_WINDOW * pwr_tenths(2'd2) / 10);
  localparam logic [WIN_W-1:0] ON_SECS_3 = WIN_W'(PWR_WINDOW * pwr_tenths(2'd3) / 10);

  state_e                r_state, w_state_nxt;
  logic [D-1:0][3:0]     r_dig, w_dig_nxt, w_dig_norm, w_dig_dec;
  logic [D-1:0][6:0]     r_segs, w_segs_nxt;
  logic                  r_start_d, r_stop_d, r_clear_d;
  logic                  w_start_edge, w_stop_edge, w_clear_edge;
  logic [TICK_W-1:0]     r_tick;
  logic                  w_tick_wrap;
  logic [WIN_W-1:0]      r_win, w_on_secs;
  logic                  w_win_clr, w_sec_step;
  logic [KEYS-1:0]       r_key_last;
  logic [DB_W-1:0]       r_db_cnt, w_db_run;
  logic                  r_armed, w_db_hit, w_key_onehot, w_key_acc;
  logic [3:0]            w_key_bcd;
  logic                  r_mag, r_done;
  logic                  w_time_nz, w_min_all9, w_carry, w_borrow, w_dec_zero;

  // Buttons act on their 1->0 transition.
  assign w_start_edge = r_start_d & ~bus.startn;
  assign w_stop_edge  = r_stop_d  & ~bus.stopn;
  assign w_clear_edge = r_clear_d & ~bus.clearn;

  assign w_time_nz    = (r_dig != {(4*D){1'b0}});
  assign w_tick_wrap  = (r_state == ST_COOK) && (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_key_onehot = is_onehot(bus.keypad);
  assign w_key_bcd    = onehot_to_bcd(bus.keypad);

  // Length of the current run of identical keypad samples, this cycle included.
  always_comb begin
    if (bus.keypad == r_key_last) begin
      w_db_run = r_db_cnt + DB_W'(1);
    end else begin
      w_db_run = DB_W'(1);
    end
  end

  // A hit fires once, on the cycle the run reaches DEBOUNCE; the stored count
  // saturates at DEBOUNCE so a held key cannot hit again.
  assign w_db_hit  = (w_db_run == DB_W'(DEBOUNCE));
  assign w_key_acc = w_db_hit && r_armed && w_key_onehot;

  // Keypad debounce state and rearm latch.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_key_last <= {KEYS{1'b0}};
      r_db_cnt   <= {DB_W{1'b0}};
      r_armed    <= 1'b1;
    end else begin
      r_key_last <= bus.keypad;
      r_db_cnt   <= (w_db_run > DB_W'(DEBOUNCE)) ? DB_W'(DEBOUNCE) : w_db_run;
      if (w_db_hit && w_key_onehot) begin
        r_armed <= 1'b0;
      end else if (w_db_hit && (bus.keypad == {KEYS{1'b0}})) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Start-time normalisation: fold sec_tens >= 6 into one more minute, or
  // clamp to xx:59 when the minutes cannot grow.
  always_comb begin
    w_dig_norm = r_dig;
    w_min_all9 = 1'b1;
    w_carry    = 1'b1;
    for (int i = 2; i < D; i++) begin
      w_min_all9 = w_min_all9 & (r_dig[i] == BCD_NINE);
    end
    if (r_dig[1] >= SEC_TENS_LIM) begin
      if (w_min_all9) begin
        w_dig_norm[1] = SEC_TENS_MAX;
        w_dig_norm[0] = BCD_NINE;
      end else begin
        w_dig_norm[1] = r_dig[1] - SEC_TENS_LIM;
        for (int i = 2; i < D; i++) begin
          if (w_carry && (r_dig[i] == BCD_NINE)) begin
            w_dig_norm[i] = 4'd0;
          end else if (w_carry) begin
            w_dig_norm[i] = r_dig[i] + 4'd1;
            w_carry       = 1'b0;
          end else begin
            w_dig_norm[i] = r_dig[i];
          end
        end
      end
    end else begin
      w_dig_norm = r_dig;
    end
  end

  // One-second BCD decrement; sec_tens wraps to 5, every other digit to 9.
  always_comb begin
    w_dig_dec = r_dig;
    w_borrow  = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (w_borrow && (r_dig[i] != 4'd0)) begin
        w_dig_dec[i] = r_dig[i] - 4'd1;
        w_borrow     = 1'b0;
      end else if (w_borrow) begin
        w_dig_dec[i] = (i == 1) ? SEC_TENS_MAX : BCD_NINE;
      end else begin
        w_dig_dec[i] = r_dig[i];
      end
    end
    w_dec_zero = (w_dig_dec == {(4*D){1'b0}});
  end

  // Next state and next time. Priority: clear > door open > stop > start.
  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_win_clr   = 1'b0;
    w_sec_step  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_clear_edge) begin
          w_dig_nxt   = {(4*D){1'b0}};
          w_state_nxt = ST_IDLE;
        end else if (w_start_edge && bus.door_closed && w_time_nz) begin
          w_dig_nxt   = w_dig_norm;
          w_state_nxt = ST_COOK;
          w_win_clr   = 1'b1;
        end else if (w_key_acc) begin
          w_dig_nxt   = {r_dig[D-2:0], w_key_bcd};
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_COOK: begin
        if (w_clear_edge) begin
          w_dig_nxt   = {(4*D){1'b0}};
          w_state_nxt = ST_IDLE;
        end else if (!bus.door_closed || w_stop_edge) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick_wrap) begin
          w_dig_nxt   = w_dig_dec;
          w_sec_step  = 1'b1;
          w_state_nxt = w_dec_zero ? ST_DONE : ST_COOK;
        end else begin
          w_state_nxt = ST_COOK;
        end
      end
      ST_PAUSE: begin
        if (w_clear_edge) begin
          w_dig_nxt   = {(4*D){1'b0}};
          w_state_nxt = ST_IDLE;
        end else if (w_start_edge && bus.door_closed) begin
          w_state_nxt = ST_COOK;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_dig_nxt   = {(4*D){1'b0}};
      end
    endcase
  end

  // On-time of the duty window for the selected power level.
  always_comb begin
    case (bus.power_sel)
      2'd0:    w_on_secs = ON_SECS_0;
      2'd1:    w_on_secs = ON_SECS_1;
      2'd2:    w_on_secs = ON_SECS_2;
      default: w_on_secs = ON_SECS_3;
    endcase
  end

  // FSM state, time digits and button edge history.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_dig     <= {(4*D){1'b0}};
      r_start_d <= 1'b0;
      r_stop_d  <= 1'b0;
      r_clear_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dig     <= w_dig_nxt;
      r_start_d <= bus.startn;
      r_stop_d  <= bus.stopn;
      r_clear_d <= bus.clearn;
    end
  end

  // Second prescaler; held at zero outside COOK so each entry starts a full second.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tick <= {TICK_W{1'b0}};
    end else if ((r_state != ST_COOK) || w_tick_wrap) begin
      r_tick <= {TICK_W{1'b0}};
    end else begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

  // Seconds within the duty window; restarted on a fresh cook, kept across pause.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_win <= {WIN_W{1'b0}};
    end else if (w_win_clr) begin
      r_win <= {WIN_W{1'b0}};
    end else if (w_sec_step) begin
      r_win <= (r_win == WIN_W'(PWR_WINDOW - 1)) ? {WIN_W{1'b0}} : r_win + WIN_W'(1);
    end else begin
      r_win <= r_win;
    end
  end

  // One decoder per displayed digit, fed from the next time value so the
  // registered segments stay aligned with digits_bcd.
  for (genvar g = 0; g < D; g++) begin : g_seg
    microwave_ctrl_param_bcd_to_7seg u_seg (
      .i_bcd (w_dig_nxt[g]),
      .o_seg (w_segs_nxt[g])
    );
  end

  // Registered magnetron enable, done flag and segment outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_mag  <= 1'b0;
      r_done <= 1'b1;
      r_segs <= {D{SEG_ZERO}};
    end else begin
      r_mag  <= (r_state == ST_COOK) && bus.door_closed && (r_win < w_on_secs);
      r_done <= ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE)) &&
                (w_dig_nxt == {(4*D){1'b0}});
      r_segs <= w_segs_nxt;
    end
  end

  assign bus.digits_bcd = r_dig;
  assign bus.segs       = r_segs;
  assign bus.mag_on     = r_mag;
  assign bus.timer_done = r_done;
  assign bus.state_o    = r_state;

endmodule
